// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// 7-bit I2C target: oversampled SCL/SDA, START/STOP detect, byte receive to data_out, byte transmit from data_in.
// ACK/NACK driven open-drain; rx_ready low NACKs a write byte, no clock stretching.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  input  logic [7:0] data_in,
  input  logic       rx_ready,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WRITE, ST_WRITE_ACK, ST_READ, ST_READ_ACK, ST_WAIT_STOP
  } state_t;

  logic       scl_meta_q, scl_sync_q, scl_prev_q;
  logic       sda_meta_q, sda_sync_q, sda_prev_q;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] data_out_q, data_out_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       rw_q, rw_d;
  logic       ack_ok_q, ack_ok_d;
  logic       phase_q, phase_d;

  logic scl_rise, scl_fall, start_det, stop_det, byte_done;

  // Bus idles high, so the synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= I2C_SCL;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= I2C_SDA;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & ~sda_prev_q & sda_sync_q;
  assign byte_done = (cnt_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    data_out_d = data_out_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    ack_ok_d   = ack_ok_q;
    phase_d    = phase_q;
    if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
      phase_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      phase_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d = {shift_q[5:0], sda_sync_q};
          cnt_d   = cnt_q + 3'd1;
          if (byte_done) begin
            phase_d = 1'b0;
            if (shift_q == TARGET_ADDR) begin
              state_d  = ST_ADDR_ACK;
              busy_d   = 1'b1;
              rw_d     = sda_sync_q;
              tx_req_d = sda_sync_q;
            end else begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        // phase 0: first fall starts the ACK; phase 1: second fall ends it.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            cnt_d   = 3'd0;
            if (rw_q) begin
              shift_d  = data_in[6:0];
              sda_oe_d = ~data_in[7];
              state_d  = ST_READ;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WRITE;
            end
          end
        end
        ST_WRITE: if (scl_rise) begin
          shift_d = {shift_q[5:0], sda_sync_q};
          cnt_d   = cnt_q + 3'd1;
          if (byte_done) begin
            state_d  = ST_WRITE_ACK;
            phase_d  = 1'b0;
            ack_ok_d = rx_ready;
            if (rx_ready) begin
              data_out_d = {shift_q, sda_sync_q};
              rx_valid_d = 1'b1;
            end
          end
        end
        ST_WRITE_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = ack_ok_q;
            phase_d  = 1'b1;
          end else begin
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            if (ack_ok_q) begin
              state_d = ST_WRITE;
            end else begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        ST_READ: if (scl_fall) begin
          if (byte_done) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            phase_d  = 1'b0;
            state_d  = ST_READ_ACK;
          end else begin
            sda_oe_d = ~shift_q[6];
            shift_d  = {shift_q[5:0], 1'b1};
            cnt_d    = cnt_q + 3'd1;
          end
        end
        ST_READ_ACK: begin
          if (scl_rise && !phase_q) begin
            if (!sda_sync_q) begin
              tx_req_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              state_d  = ST_WAIT_STOP;
              busy_d   = 1'b0;
              sda_oe_d = 1'b0;
            end
          end else if (scl_fall && phase_q) begin
            shift_d  = data_in[6:0];
            sda_oe_d = ~data_in[7];
            cnt_d    = 3'd0;
            phase_d  = 1'b0;
            state_d  = ST_READ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 7'd0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      data_out_q <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      ack_ok_q   <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      ack_ok_q   <= ack_ok_d;
      phase_q    <= phase_d;
    end
  end

  assign I2C_SDA  = sda_oe_q ? 1'b0 : 1'bz;
  assign data_out = data_out_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// Bench for i2c_target: bus-master tasks drive SCL/SDA; rx/tx expectations are queued and popped by a monitor.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda_oe;
  wire        sda_bus;
  logic [7:0] data_in = 8'h00;
  logic       rx_ready;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int tx_seen  = 0;
  int drive_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_data[$];

  always #5 clk = ~clk;

  assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_target #(.TARGET_ADDR(7'h50)) dut (
    .clk(clk), .rst(rst), .I2C_SCL(m_scl), .I2C_SDA(sda_bus),
    .data_in(data_in), .rx_ready(rx_ready), .data_out(data_out),
    .rx_valid(rx_valid), .tx_req(tx_req), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected write bytes on rx_valid, supplies read bytes on tx_req,
  // and counts cycles where SDA is low while the master has released it.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: got rx_valid with data_out 0x%0h, expected no pulse", data_out);
        end else begin
          chk("rx_data", {24'd0, data_out}, {24'd0, exp_rx.pop_front()});
        end
      end
      if (tx_req) begin
        tx_seen++;
        if (tx_data.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected: got tx_req pulse, expected none");
        end else begin
          data_in = tx_data.pop_front();
        end
      end
      if (!m_sda_oe && sda_bus === 1'b0) drive_cnt++;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_oe = 1'b0;
    clks(5);
    m_scl = 1'b1;
    clks(10);
    m_sda_oe = 1'b1;
    clks(10);
    m_scl = 1'b0;
    clks(5);
  endtask

  task automatic bus_stop();
    m_sda_oe = 1'b1;
    clks(5);
    m_scl = 1'b1;
    clks(10);
    m_sda_oe = 1'b0;
    clks(10);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda_oe = ~b;
    clks(5);
    m_scl = 1'b1;
    clks(5);
    s = sda_bus;
    clks(5);
    m_scl = 1'b0;
    clks(5);
  endtask

  // Returns the SDA level seen in the 9th clock (0 = ACK).
  task automatic write_byte(input logic [7:0] b, output logic ack_lvl);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack_lvl);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~master_ack, s);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       s;
    logic [7:0] rb;
    int         snap;
    int         tx0;

    rst = 1'b0;
    m_scl = 1'b1;
    m_sda_oe = 1'b0;
    rx_ready = 1'b1;
    clks(5);
    rst = 1'b1;
    clks(5);
    chk("rst_data_out", {24'd0, data_out}, 32'h00);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sda", {31'd0, sda_bus}, 32'd1);

    // Write 0x3C to address 0x50
    bus_start();
    write_byte(8'hA0, s);
    chk("wr_addr_ack", {31'd0, s}, 32'd0);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    exp_rx.push_back(8'h3C);
    write_byte(8'h3C, s);
    chk("wr_data_ack", {31'd0, s}, 32'd0);
    bus_stop();
    clks(5);
    chk("wr_busy_after_stop", {31'd0, busy}, 32'd0);
    chk("wr_data_out", {24'd0, data_out}, 32'h3C);
    chk("wr_rx_pending", exp_rx.size(), 32'd0);

    // Address mismatch
    snap = drive_cnt;
    bus_start();
    write_byte(8'hA2, s);
    chk("mm_addr_nack", {31'd0, s}, 32'd1);
    chk("mm_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h55, s);
    chk("mm_data_nack", {31'd0, s}, 32'd1);
    bus_stop();
    clks(5);
    chk("mm_no_drive", drive_cnt - snap, 32'd0);
    chk("mm_data_out", {24'd0, data_out}, 32'h3C);

    // Read two bytes, ACK then NACK
    tx0 = tx_seen;
    tx_data.push_back(8'hC5);
    tx_data.push_back(8'h19);
    bus_start();
    write_byte(8'hA1, s);
    chk("rd_addr_ack", {31'd0, s}, 32'd0);
    read_byte(1'b1, rb);
    chk("rd_byte0", {24'd0, rb}, 32'hC5);
    read_byte(1'b0, rb);
    chk("rd_byte1", {24'd0, rb}, 32'h19);
    clks(2);
    chk("rd_busy_after_nack", {31'd0, busy}, 32'd0);
    snap = drive_cnt;
    write_byte(8'hA1, s);
    chk("rd_wait_stop_ignored", {31'd0, s}, 32'd1);
    chk("rd_wait_stop_no_drive", drive_cnt - snap, 32'd0);
    bus_stop();
    clks(5);
    chk("rd_tx_req_count", tx_seen - tx0, 32'd2);
    chk("rd_tx_pending", tx_data.size(), 32'd0);

    // Backpressure: rx_ready low NACKs the data byte
    rx_ready = 1'b0;
    bus_start();
    write_byte(8'hA0, s);
    chk("bp_addr_ack", {31'd0, s}, 32'd0);
    write_byte(8'h77, s);
    chk("bp_data_nack", {31'd0, s}, 32'd1);
    chk("bp_busy", {31'd0, busy}, 32'd0);
    snap = drive_cnt;
    write_byte(8'h12, s);
    chk("bp_ignored_nack", {31'd0, s}, 32'd1);
    chk("bp_no_drive", drive_cnt - snap, 32'd0);
    bus_stop();
    clks(5);
    chk("bp_data_out", {24'd0, data_out}, 32'h3C);
    rx_ready = 1'b1;

    // Repeated START: write 0x10 then read without STOP
    bus_start();
    write_byte(8'hA0, s);
    chk("sr_addr_ack", {31'd0, s}, 32'd0);
    exp_rx.push_back(8'h10);
    write_byte(8'h10, s);
    chk("sr_data_ack", {31'd0, s}, 32'd0);
    chk("sr_busy_write", {31'd0, busy}, 32'd1);
    bus_start();
    chk("sr_busy_after_sr", {31'd0, busy}, 32'd1);
    tx_data.push_back(8'h5A);
    write_byte(8'hA1, s);
    chk("sr_rd_addr_ack", {31'd0, s}, 32'd0);
    chk("sr_busy_read", {31'd0, busy}, 32'd1);
    read_byte(1'b0, rb);
    chk("sr_rd_byte", {24'd0, rb}, 32'h5A);
    bus_stop();
    clks(5);
    chk("sr_data_out", {24'd0, data_out}, 32'h10);
    chk("sr_rx_pending", exp_rx.size(), 32'd0);
    chk("sr_busy_after_stop", {31'd0, busy}, 32'd0);

    // Reset while the target drives a 0 data bit
    tx_data.push_back(8'h3F);
    bus_start();
    write_byte(8'hA1, s);
    chk("rr_addr_ack", {31'd0, s}, 32'd0);
    clks(2);
    chk("rr_driving_low", {31'd0, sda_bus}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rr_sda_released", {31'd0, sda_bus}, 32'd1);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_tx_req", {31'd0, tx_req}, 32'd0);
    chk("rr_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rr_data_out", {24'd0, data_out}, 32'h00);
    clks(3);
    rst = 1'b1;
    clks(5);
    bus_start();
    write_byte(8'hA0, s);
    chk("rr_next_addr_ack", {31'd0, s}, 32'd0);
    exp_rx.push_back(8'h66);
    write_byte(8'h66, s);
    chk("rr_next_data_ack", {31'd0, s}, 32'd0);
    bus_stop();
    clks(5);
    chk("rr_next_data_out", {24'd0, data_out}, 32'h66);
    chk("rr_rx_pending", exp_rx.size(), 32'd0);
    chk("rr_tx_pending", tx_data.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
